// File: rtl/mp_adder_seq_pkg.sv
// Shared definitions for the sequential multi-precision adder: FSM encoding,
// default operand/slice widths and a counter-width helper.
package mp_adder_seq_pkg;

  localparam int DEF_OPERAND_WIDTH = 64;
  localparam int DEF_SLICE_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-slice configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int nslices);
    return (nslices > 1) ? $clog2(nslices) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_Nb.sv
// Combinational ripple-carry adder of ADDER_WIDTH bits with carry-in and carry-out.
// The carry chain is walked bit by bit, LSB first.
module ripple_carry_adder_Nb #(
  parameter int ADDER_WIDTH = 16
) (
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  input  logic                   cin,
  output logic [ADDER_WIDTH-1:0] sum,
  output logic                   cout
);

  logic [ADDER_WIDTH-1:0] prop;
  logic [ADDER_WIDTH-1:0] gen;

  for (genvar gi = 0; gi < ADDER_WIDTH; gi++) begin : g_pg
    assign prop[gi] = a[gi] ^ b[gi];
    assign gen[gi]  = a[gi] & b[gi];
  end

  // The carry is kept in a procedural variable so the chain is not a
  // self-referencing vector.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      sum[i] = prop[i] ^ c;
      c      = gen[i] | (prop[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/mp_adder_seq.sv
// Sequential multi-precision adder: adds two OPERAND_WIDTH operands one
// SLICE_WIDTH slice per clock, with valid/ready handshakes on both sides.
module mp_adder_seq
  import mp_adder_seq_pkg::*;
#(
  parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
  parameter int SLICE_WIDTH   = DEF_SLICE_WIDTH
) (
  input  logic                     iClk,
  input  logic                     iRstn,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  input  logic                     iCarry,
  output logic [OPERAND_WIDTH-1:0] oSum,
  output logic                     oCarry,
  output logic                     oValid,
  input  logic                     iReady
);

  localparam int NSLICES = OPERAND_WIDTH / SLICE_WIDTH;
  localparam int CNT_W   = cnt_width(NSLICES);
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICES - 1);

  state_t state_reg;
  state_t state_next;

  logic [OPERAND_WIDTH-1:0] a_reg;
  logic [OPERAND_WIDTH-1:0] b_reg;
  logic                     carry_reg;
  logic [CNT_W-1:0]         cnt_reg;
  logic [OPERAND_WIDTH-1:0] sum_reg;
  logic [OPERAND_WIDTH-1:0] sum_next;
  logic                     cout_reg;

  logic [SLICE_WIDTH-1:0]   slice_sum;
  logic                     slice_cout;
  logic                     accept;
  logic                     add_step;
  logic                     last_slice;

  assign accept     = (state_reg == ST_IDLE) && iValid;
  assign add_step   = (state_reg == ST_ADD);
  assign last_slice = add_step && (cnt_reg == LAST_SLICE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (iValid)     state_next = ST_ADD;
      ST_ADD:  if (last_slice) state_next = ST_DONE;
      ST_DONE: if (iReady)     state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    oReady = 1'b0;
    oValid = 1'b0;
    case (state_reg)
      ST_IDLE: oReady = 1'b1;
      ST_DONE: oValid = 1'b1;
      default: ;
    endcase
  end

  // The low slice of the shifted operands is always the one being added.
  ripple_carry_adder_Nb #(
    .ADDER_WIDTH(SLICE_WIDTH)
  ) u_slice_adder (
    .a    (a_reg[SLICE_WIDTH-1:0]),
    .b    (b_reg[SLICE_WIDTH-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Only the slice addressed by the counter takes the new partial sum.
  for (genvar gi = 0; gi < NSLICES; gi++) begin : g_sum_slice
    assign sum_next[gi*SLICE_WIDTH +: SLICE_WIDTH] =
      (cnt_reg == CNT_W'(gi)) ? slice_sum : sum_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
  end

  // ---------------- datapath ----------------
  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_reg     <= iA;
      b_reg     <= iB;
      carry_reg <= iCarry;
      cnt_reg   <= '0;
    end else if (add_step) begin
      a_reg     <= a_reg >> SLICE_WIDTH;
      b_reg     <= b_reg >> SLICE_WIDTH;
      carry_reg <= slice_cout;
      cnt_reg   <= cnt_reg + CNT_W'(1);
      sum_reg   <= sum_next;
      if (last_slice) begin
        cout_reg <= slice_cout;
      end
    end
  end

  assign oSum   = sum_reg;
  assign oCarry = cout_reg;

endmodule

// File: tb/tb_mp_adder_seq.sv
// Self-checking bench for mp_adder_seq: directed corner cases, a mid-add reset
// and randomized operands against a plain-arithmetic reference.
module tb_mp_adder_seq;

  localparam int W  = 64;
  localparam int SW = 16;
  localparam int NS = W / SW;

  logic         iClk = 1'b0;
  logic         iRstn;
  logic         iValid;
  logic         oReady;
  logic [W-1:0] iA;
  logic [W-1:0] iB;
  logic         iCarry;
  logic [W-1:0] oSum;
  logic         oCarry;
  logic         oValid;
  logic         iReady;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  mp_adder_seq #(
    .OPERAND_WIDTH(W),
    .SLICE_WIDTH  (SW)
  ) dut (
    .iClk   (iClk),
    .iRstn  (iRstn),
    .iValid (iValid),
    .oReady (oReady),
    .iA     (iA),
    .iB     (iB),
    .iCarry (iCarry),
    .oSum   (oSum),
    .oCarry (oCarry),
    .oValid (oValid),
    .iReady (iReady)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // One full transaction: accept, wait for the result, hold in DONE, release.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int hold, input bit noise, input int id);
    int         lat;
    logic [W:0] exp;
    exp = ref_add(a, b, c);
    lat = 0;
    while (!oReady && lat < 20) begin
      step();
      lat++;
    end
    check("ready_wait", 128'(oReady), 128'(1));
    iA     = a;
    iB     = b;
    iCarry = c;
    iValid = 1'b1;
    iReady = 1'b0;
    step();
    lat = 0;
    while (!oValid && lat < 20) begin
      if (noise) begin
        iValid = 1'($urandom_range(0, 1));
        iA     = {$urandom, $urandom};
        iB     = {$urandom, $urandom};
        iCarry = 1'($urandom_range(0, 1));
      end else begin
        iValid = 1'b0;
      end
      step();
      lat++;
    end
    check("latency", 128'(lat), 128'(NS));
    check("result", 128'({oCarry, oSum}), 128'(exp));
    for (int h = 0; h < hold; h++) begin
      iValid = 1'($urandom_range(0, 1));
      iA     = {$urandom, $urandom};
      iB     = {$urandom, $urandom};
      iCarry = 1'($urandom_range(0, 1));
      step();
      check("hold", 128'({oValid, oReady, oCarry, oSum}), 128'({1'b1, 1'b0, exp}));
    end
    iValid = 1'b0;
    iReady = 1'b1;
    step();
    iReady = 1'b0;
    check("release", 128'({oValid, oReady}), 128'(2'b01));
    check("kept", 128'({oCarry, oSum}), 128'(exp));
    $display("op %0d a=%h b=%h cin=%0d -> cout=%0d sum=%h (lat %0d)",
             id, a, b, c, oCarry, oSum, lat);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           wait_cnt;

    // Reset with a pending request: reset must win.
    iRstn  = 1'b0;
    iValid = 1'b1;
    iReady = 1'b1;
    iA     = '1;
    iB     = '1;
    iCarry = 1'b1;
    repeat (3) step();
    check("rst_ready", 128'(oReady), 128'(1));
    check("rst_valid", 128'(oValid), 128'(0));
    check("rst_sum", 128'({oCarry, oSum}), 128'(0));
    iValid = 1'b0;
    iReady = 1'b0;
    iRstn  = 1'b1;
    step();
    check("idle_after_rst", 128'({oValid, oReady}), 128'(2'b01));

    // Directed corner cases.
    do_op('1, 64'd1, 1'b0, 0, 1'b0, 0);
    do_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 0, 1'b0, 1);
    do_op('0, '0, 1'b1, 0, 1'b0, 2);
    do_op('1, '1, 1'b1, 0, 1'b0, 3);
    do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 3, 1'b1, 4);

    // Reset asserted while the third slice is being added.
    wait_cnt = 0;
    while (!oReady && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    iA     = 64'hFFFF_FFFF_FFFF_FFFF;
    iB     = 64'h0000_0000_0000_0001;
    iCarry = 1'b1;
    iValid = 1'b1;
    step();
    iValid = 1'b0;
    step();
    step();
    iRstn = 1'b0;
    step();
    iRstn = 1'b1;
    check("midrst_flags", 128'({oValid, oReady}), 128'(2'b01));
    check("midrst_result", 128'({oCarry, oSum}), 128'(0));
    wait_cnt = 0;
    while (wait_cnt < NS + 2) begin
      step();
      check("midrst_no_valid", 128'(oValid), 128'(0));
      wait_cnt++;
    end
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1, 1'b1, 5);

    // Randomized operands, gaps and hold times.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ra = '1;
      if ($urandom_range(0, 7) == 0) rb = W'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) step();
      do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1, 100 + i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
